// File: rtl/wb_sched_if.sv
// Writeback scheduler bus: four completion sources in, two register-file write ports
// and a retired-instruction count out.
interface wb_sched_if;
  logic [3:0]   src_valid;
  logic [3:0]   src_wb_en;
  logic [19:0]  src_dst;
  logic [255:0] src_result;
  logic [3:0]   src_ready;
  logic         rf_wen0;
  logic [4:0]   rf_wdst0;
  logic [63:0]  rf_wdata0;
  logic         rf_wen1;
  logic [4:0]   rf_wdst1;
  logic [63:0]  rf_wdata1;
  logic [2:0]   wb_instret;

  modport slave (
    input  src_valid, src_wb_en, src_dst, src_result,
    output src_ready, rf_wen0, rf_wdst0, rf_wdata0,
           rf_wen1, rf_wdst1, rf_wdata1, wb_instret
  );

  modport master (
    output src_valid, src_wb_en, src_dst, src_result,
    input  src_ready, rf_wen0, rf_wdst0, rf_wdata0,
           rf_wen1, rf_wdst1, rf_wdata1, wb_instret
  );
endinterface

// File: rtl/wb_sched.sv
// Writeback scheduler: round-robin grant of two RF write ports among lsp/md/ip0/ip1,
// with a starvation override on port 0 and same-destination conflict blocking on port 1.
module wb_sched #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic      clk,
  input  logic      rst,
  wb_sched_if.slave bus
);
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [1:0]  rr_ptr;
  logic [2:0]  starve [4];
  logic [4:0]  dst    [4];
  logic [63:0] result [4];

  logic [3:0] req, sink, cand, grant, handshake;
  logic       p0_vld, p1_vld;
  logic [1:0] p0_idx, p1_idx, last_idx;
  logic       forced;
  logic [2:0] hs_count;

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
    return base + 2'(k);
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dst[i]    = bus.src_dst[5*i +: 5];
      result[i] = bus.src_result[64*i +: 64];
    end
  end

  assign req  = bus.src_valid & bus.src_wb_en;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sink[i] = req[i] && (dst[i] == 5'd0);
      cand[i] = req[i] && (dst[i] != 5'd0);
    end
  end

  // Descending loops with overwrite leave the lowest index / nearest-in-order winner.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    p0_vld   = 1'b0;
    p0_idx   = 2'd0;
    p1_vld   = 1'b0;
    p1_idx   = 2'd0;
    forced   = 1'b0;
    last_idx = rr_ptr;
    grant    = 4'b0000;

    for (int i = 3; i >= 0; i--) begin
      if (cand[i] && starve[i] == LIMIT) begin
        forced = 1'b1;
        p0_idx = 2'(i);
      end
    end
    p0_vld = forced;

    if (!forced) begin
      for (int k = 3; k >= 0; k--) begin
        if (cand[rr_idx(rr_ptr, k)]) begin
          p0_vld = 1'b1;
          p0_idx = rr_idx(rr_ptr, k);
        end
      end
    end

    // Port 1 skips the port-0 grantee and anything colliding with its destination.
    for (int k = 3; k >= 0; k--) begin
      if (p0_vld && cand[rr_idx(rr_ptr, k)] && rr_idx(rr_ptr, k) != p0_idx &&
          dst[rr_idx(rr_ptr, k)] != dst[p0_idx]) begin
        p1_vld = 1'b1;
        p1_idx = rr_idx(rr_ptr, k);
      end
    end

    if (p0_vld) grant[p0_idx] = 1'b1;
    if (p1_vld) grant[p1_idx] = 1'b1;

    for (int k = 0; k < 4; k++) begin
      if (grant[rr_idx(rr_ptr, k)]) last_idx = rr_idx(rr_ptr, k);
    end
  end

  assign bus.src_ready = ~req | sink | grant;
  assign handshake     = bus.src_valid & bus.src_ready;

  assign bus.rf_wen0   = p0_vld;
  assign bus.rf_wdst0  = dst[p0_idx];
  assign bus.rf_wdata0 = result[p0_idx];
  assign bus.rf_wen1   = p1_vld;
  assign bus.rf_wdst1  = dst[p1_idx];
  assign bus.rf_wdata1 = result[p1_idx];

  always_comb begin
    hs_count = 3'd0;
    for (int i = 0; i < 4; i++) hs_count = hs_count + 3'(handshake[i]);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr         <= 2'd0;
      bus.wb_instret <= 3'd0;
      // NOTE: the starve counters are a handful of flops, not a RAM, so each one is reset explicitly.
      for (int i = 0; i < 4; i++) starve[i] <= 3'd0;
    end else begin
      if (|grant) rr_ptr <= last_idx + 2'd1;
      bus.wb_instret <= hs_count;
      for (int i = 0; i < 4; i++) begin
        if (cand[i] && !grant[i])
          starve[i] <= (starve[i] < LIMIT) ? starve[i] + 3'd1 : starve[i];
        else
          starve[i] <= 3'd0;
      end
    end
  end
endmodule

// File: tb/tb_wb_sched.sv
// Scoreboard bench for wb_sched: two instances (STARVE_LIMIT 3 and 1) share stimulus;
// a queue-based reference model predicts each cycle and a negedge monitor compares.
module tb_wb_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_sched_if bus0 ();
  wb_sched_if bus1 ();

  wb_sched #(.STARVE_LIMIT(3)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  wb_sched #(.STARVE_LIMIT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct packed {
    logic [3:0]  rdy;
    logic        wen0;
    logic [4:0]  dst0;
    logic [63:0] data0;
    logic        wen1;
    logic [4:0]  dst1;
    logic [63:0] data1;
    logic [2:0]  instret;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int tests = 0;
  int fails = 0;

  int lim  [2] = '{3, 1};
  int m_rr [2];
  int m_ir [2];
  int m_st [2][4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare(input int u, input exp_t e, input exp_t a);
    string p;
    p = $sformatf("dut%0d", u);
    check({p, " src_ready"}, 64'(a.rdy), 64'(e.rdy));
    check({p, " rf_wen0"}, 64'(a.wen0), 64'(e.wen0));
    if (e.wen0) begin
      check({p, " rf_wdst0"}, 64'(a.dst0), 64'(e.dst0));
      check({p, " rf_wdata0"}, a.data0, e.data0);
    end
    check({p, " rf_wen1"}, 64'(a.wen1), 64'(e.wen1));
    if (e.wen1) begin
      check({p, " rf_wdst1"}, 64'(a.dst1), 64'(e.dst1));
      check({p, " rf_wdata1"}, a.data1, e.data1);
    end
    check({p, " wb_instret"}, 64'(a.instret), 64'(e.instret));
  endtask

  // Reference: list the writers in round-robin order, pick starving source first,
  // then the first list entry not already taken and not sharing port 0's destination.
  task automatic model(input int limit, input int rr, input int st[4],
                       input logic [3:0] v, input logic [3:0] w, input logic [4:0] d[4],
                       output int p0, output int p1, output logic [3:0] rdy);
    int order[$];
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = (rr + k) % 4;
      if (v[idx] && w[idx] && d[idx] != 0) order.push_back(idx);
    end
    p0 = -1;
    for (int i = 3; i >= 0; i--)
      if (v[i] && w[i] && d[i] != 0 && st[i] == limit) p0 = i;
    if (p0 < 0 && order.size() > 0) p0 = order[0];
    p1 = -1;
    foreach (order[k])
      if (p1 < 0 && order[k] != p0 && d[order[k]] != d[p0]) p1 = order[k];
    for (int i = 0; i < 4; i++)
      rdy[i] = !(v[i] && w[i]) || d[i] == 0 || i == p0 || i == p1;
  endtask

  task automatic drive_cycle(input logic r, input logic [3:0] v, input logic [3:0] w,
                             input logic [4:0] d[4], input logic [63:0] res[4], input bit push);
    logic [19:0]  dbus;
    logic [255:0] rbus;
    int st[4];
    int p0, p1, last;
    logic [3:0] rdy;
    exp_t e;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      dbus[5*i +: 5]   = d[i];
      rbus[64*i +: 64] = res[i];
    end
    rst = r;
    bus0.src_valid = v; bus0.src_wb_en = w; bus0.src_dst = dbus; bus0.src_result = rbus;
    bus1.src_valid = v; bus1.src_wb_en = w; bus1.src_dst = dbus; bus1.src_result = rbus;
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 4; i++) st[i] = m_st[u][i];
      model(lim[u], m_rr[u], st, v, w, d, p0, p1, rdy);
      e = '0;
      e.rdy     = rdy;
      e.wen0    = (p0 >= 0);
      e.wen1    = (p1 >= 0);
      if (p0 >= 0) begin e.dst0 = d[p0]; e.data0 = res[p0]; end
      if (p1 >= 0) begin e.dst1 = d[p1]; e.data1 = res[p1]; end
      e.instret = 3'(m_ir[u]);
      if (push) begin
        if (u == 0) q0.push_back(e); else q1.push_back(e);
      end
      if (r) begin
        m_rr[u] = 0; m_ir[u] = 0;
        for (int i = 0; i < 4; i++) m_st[u][i] = 0;
      end else begin
        if (p0 >= 0) begin
          last = p0;
          if (p1 >= 0 && ((p1 - m_rr[u] + 4) % 4) > ((p0 - m_rr[u] + 4) % 4)) last = p1;
          m_rr[u] = (last + 1) % 4;
        end
        m_ir[u] = $countones(v & rdy);
        for (int i = 0; i < 4; i++) begin
          if (v[i] && w[i] && d[i] != 0 && i != p0 && i != p1)
            m_st[u][i] = (m_st[u][i] < lim[u]) ? m_st[u][i] + 1 : m_st[u][i];
          else
            m_st[u][i] = 0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t a;
    if (q0.size() > 0) begin
      a = {bus0.src_ready, bus0.rf_wen0, bus0.rf_wdst0, bus0.rf_wdata0,
           bus0.rf_wen1, bus0.rf_wdst1, bus0.rf_wdata1, bus0.wb_instret};
      compare(0, q0.pop_front(), a);
    end
    if (q1.size() > 0) begin
      a = {bus1.src_ready, bus1.rf_wen0, bus1.rf_wdst0, bus1.rf_wdata0,
           bus1.rf_wen1, bus1.rf_wdst1, bus1.rf_wdata1, bus1.wb_instret};
      compare(1, q1.pop_front(), a);
    end
  end

  logic [4:0]  d   [4];
  logic [63:0] res [4];

  task automatic rand_res();
    for (int i = 0; i < 4; i++) res[i] = {$urandom, $urandom};
  endtask

  task automatic set_dst(input int a, input int b, input int c, input int e);
    d[0] = 5'(a); d[1] = 5'(b); d[2] = 5'(c); d[3] = 5'(e);
  endtask

  initial begin
    rst = 1'b1;
    bus0.src_valid = '0; bus0.src_wb_en = '0; bus0.src_dst = '0; bus0.src_result = '0;
    bus1.src_valid = '0; bus1.src_wb_en = '0; bus1.src_dst = '0; bus1.src_result = '0;
    set_dst(0, 0, 0, 0);
    rand_res();
    drive_cycle(1'b1, 4'b0000, 4'b0000, d, res, 1'b0);
    drive_cycle(1'b1, 4'b0111, 4'b1111, d, res, 1'b1);

    // Three writers from rr_ptr 0: lsp and md win, ip0 waits.
    set_dst(1, 2, 3, 0); rand_res();
    drive_cycle(1'b0, 4'b0111, 4'b1111, d, res, 1'b1);
    // ip0/ip1 collide on dst 5 from rr_ptr 2.
    set_dst(0, 0, 5, 5); rand_res();
    drive_cycle(1'b0, 4'b1100, 4'b1111, d, res, 1'b1);
    drive_cycle(1'b0, 4'b1000, 4'b1111, d, res, 1'b1);
    // Retire-only, sink and a real write all in one cycle, then the count.
    set_dst(9, 0, 7, 0); rand_res();
    drive_cycle(1'b0, 4'b0111, 4'b0110, d, res, 1'b1);
    drive_cycle(1'b0, 4'b0000, 4'b0000, d, res, 1'b1);

    // Starvation of ip1 from a fresh reset.
    drive_cycle(1'b1, 4'b0000, 4'b0000, d, res, 1'b1);
    set_dst(1, 2, 0, 4); rand_res();
    drive_cycle(1'b0, 4'b1011, 4'b1111, d, res, 1'b1);
    drive_cycle(1'b0, 4'b1011, 4'b1111, d, res, 1'b1);
    drive_cycle(1'b0, 4'b1011, 4'b1111, d, res, 1'b1);

    // Continuous full contention with distinct destinations.
    set_dst(11, 12, 13, 14);
    for (int c = 0; c < 16; c++) begin
      rand_res();
      drive_cycle(1'b0, 4'b1111, 4'b1111, d, res, 1'b1);
    end
    // Reset mid-contention, then arbitration restarts.
    drive_cycle(1'b1, 4'b1111, 4'b1111, d, res, 1'b1);
    for (int c = 0; c < 4; c++) drive_cycle(1'b0, 4'b1111, 4'b1111, d, res, 1'b1);

    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++) d[i] = 5'($urandom_range(0, 6));
      rand_res();
      drive_cycle(($urandom_range(0, 49) == 0), 4'($urandom), 4'($urandom | $urandom),
                  d, res, 1'b1);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_sched.md
WB_SCHED -- requirements
Module: wb_sched

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, meaning the consecutive-denial count (1..7) at which a source is forced onto port 0.
REQ-002 SHALL have ports clk (input, 1, single clock) and rst (input, 1, synchronous active-high reset).
REQ-003 SHALL have port src_valid (input, 4): per-source completion valid; index 0=lsp, 1=md, 2=ip0, 3=ip1.
REQ-004 SHALL have port src_wb_en (input, 4): per-source register write requested; 0 means retire without writeback.
REQ-005 SHALL have port src_dst (input, 20): per-source destination, 5 bits each, source i at [5i+4:5i].
REQ-006 SHALL have port src_result (input, 256): per-source result, 64 bits each, source i at [64i+63:64i].
REQ-007 SHALL have port src_ready (output, 4): per-source accept; a handshake occurs when src_valid[i] and src_ready[i] are both high.
REQ-008 SHALL have ports rf_wen0 (output, 1), rf_wdst0 (output, 5) and rf_wdata0 (output, 64): register file write port 0.
REQ-009 SHALL have ports rf_wen1 (output, 1), rf_wdst1 (output, 5) and rf_wdata1 (output, 64): register file write port 1.
REQ-010 SHALL have port wb_instret (output, 3): handshake count from the previous cycle.

Function
REQ-011 SHALL treat source i as requesting when src_valid[i] && src_wb_en[i] (req[i]), and as retire-only when src_valid[i] && !src_wb_en[i].
REQ-012 SHALL drive src_ready[i]=1 in the same cycle for a retire-only source, and for any source with src_valid[i]=0.
REQ-013 SHALL treat a request with dst==0 as a sink: ready in the same cycle, no port consumed, no rf_wen asserted.
REQ-014 SHALL grant at most 2 of the remaining requests per cycle, combinationally: port 0 to the first request in round-robin order from rr_ptr, port 1 to the second.
REQ-015 SHALL maintain a 3-bit starve counter per source:
- +1 (saturating at STARVE_LIMIT) when req[i], dst!=0 and not granted;
- cleared when granted or when not requesting.
REQ-016 SHALL give port 0 to the lowest-index source whose starve counter equals STARVE_LIMIT; port 1 then goes to the first other request in round-robin order.
REQ-017 SHALL NOT grant port 1 when its candidate has the same dst as the port 0 grantee; the candidate stays waiting (ready=0), and port 1 may go to the next candidate in order.
REQ-018 SHALL drive src_ready[i]=1 for granted sources and 0 for requesting, non-granted sources.
REQ-019 SHALL update rr_ptr on each clock edge with any grant to (index of last granted source in round-robin order + 1) mod 4; it SHALL hold when nothing is granted.
REQ-020 SHALL drive rf_wenN low when port N is unused; rf_wdstN and rf_wdataN are don't-care in that case.
REQ-021 SHALL register wb_instret as the popcount of (src_valid & src_ready) sampled at each edge; range 0..4.
REQ-022 SHALL hold no data state; a source held off keeps its valid/dst/result stable until ready.

Reset
REQ-023 SHALL, while rst=1 at the edge, clear rr_ptr to 0, all starve counters to 0 and wb_instret to 0; reset mid-contention discards starvation history.
REQ-024 SHALL keep its combinational outputs driven during reset by the REQ-011..020 rules applied to the reset state values.

Verification
REQ-025 SHALL be verified with: rr_ptr=0; lsp, md and ip0 request with dsts 1, 2, 3 -> port0=lsp (dst 1), port1=md (dst 2), ip0 ready=0, next rr_ptr=2.
REQ-026 SHALL be verified with: all 4 sources requesting continuously with distinct nonzero dsts -> every source granted at least once in any 2 consecutive cycles.
REQ-027 SHALL be verified with: ip0 and ip1 both writing dst 5, rr_ptr=2 -> only ip0 granted; ip1 granted the following cycle.
REQ-028 SHALL be verified with: lsp retire-only, md with dst 0, ip0 with dst 7 -> all three ready in the same cycle, only rf_wen0 high (dst 7), wb_instret=3 one cycle later.
REQ-029 SHALL be verified with: STARVE_LIMIT=1 and ip1 denied once -> next cycle ip1 on port 0 regardless of rr_ptr, and its counter returns to 0.
REQ-030 SHALL be verified with: rst asserted for one cycle while requests are pending -> rr_ptr=0, wb_instret=0 and counters 0 afterwards, arbitration restarting from lsp.
